id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Hazard and operand-bypass controller for the ID stage. It keeps a shadow copy of the destination registers of instructions in EX, MEM and WB, and compares them with the read and write requests that the ID register-address generator produces. From that comparison it drives the ID issue handshake, inserts load-use bubbles, selects bypass sources for both read ports, and honours memory stalls and pipeline flushes. It sits between the ID stage and the EX pipeline register and has no data path of its own.

## Interface
- No parameters.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a valid instruction.
- `reg_read_en_1`, `reg_read_en_2` in 1 each: read port enables from ID.
- `reg_addr_1`, `reg_addr_2` in 5 each: read port addresses from ID.
- `reg_write_en` in 1: the ID instruction writes a register.
- `reg_write_addr` in 5: destination register of the ID instruction.
- `id_is_load` in 1: the ID instruction is LB, LBU or LW.
- `mem_stall` in 1: memory stage is not ready; the whole pipeline freezes.
- `flush` in 1: one-cycle pulse that squashes the instruction in ID.
- `id_ready` out 1: ID may issue into EX this cycle.
- `fwd_sel_1`, `fwd_sel_2` out 2 each: bypass source per port. 00 = register file, 01 = EX, 10 = MEM, 11 = WB.
- `load_use_stall` out 1: a load-use hazard is holding ID.
- `stall_cnt` out 16: saturating count of stalled cycles.

## Operation
- Shadow pipeline: three slots, EX, MEM and WB. Each slot is {v, waddr[4:0], ld}.
- Issue: an issue occurs when `id_valid && id_ready` and `flush_eff` is 0.
- On issue, the EX slot loads v = `reg_write_en && reg_write_addr != 0`, waddr = `reg_write_addr`, ld = `id_is_load`. In every other case the EX slot loads a bubble (v = 0).
- Port match: a port matches a slot when all of the following hold:
  - the port's `reg_read_en` is 1;
  - the port address is not 0;
  - the slot's v is 1;
  - the slot's waddr equals the port address.
- Bypass select: the youngest matching slot wins, in the order EX, then MEM, then WB. With no match the select is 00. The select is computed combinationally from the current slots and is valid whether or not ID stalls.
- Load-use hazard: `load_use_stall` = `id_valid` && (either port matches the EX slot with ld = 1). Register 0 never creates a hazard or a bypass.
- `id_ready` = !`mem_stall` && !`load_use_stall`. It is not a function of `flush`.
- Flush handling:
  - `flush_pend` is a 1-bit register.
  - `flush_eff` = `flush` || `flush_pend`.
  - If `flush` is asserted while `mem_stall` = 1, `flush_pend` is set on that edge.
  - `flush_pend` clears on the first edge with `mem_stall` = 0, which is the edge where the flush takes effect.
  - A flush squashes only the ID instruction: the EX slot loads a bubble. MEM and WB advance normally.
- Stall counter: `stall_cnt` increments on each edge where `id_valid && !id_ready`. It saturates at 16'hFFFF and does not wrap.

## Timing
- Reset (asynchronous): all slot v and ld bits are 0, all waddr are 0, `flush_pend` = 0, `stall_cnt` = 0.
- Outputs in reset: `id_ready` = !`mem_stall`, `load_use_stall` = 0, `fwd_sel_1` and `fwd_sel_2` = 00.
- Advance edge (`mem_stall` = 0): WB <= MEM, MEM <= EX, EX <= issue entry or bubble.
- Stall edge (`mem_stall` = 1): all three slots hold, and no issue is possible. `stall_cnt` still counts if `id_valid` = 1.
- Load-use stall latency: exactly one bubble. On the following cycle the load sits in MEM, the stall drops and the select is 10.
- Simultaneous events:
  - `mem_stall` together with a load-use hazard: one stall cycle per cycle, not doubled; the slots hold.
  - `flush` together with a load-use hazard: the EX slot loads a bubble, which would happen anyway.
  - An instruction that reads and writes the same register (e.g. `addiu $t0,$t0,1`) compares against the older slots only, never against itself.
- Reset asserted mid-stall or with a flush pending: everything clears immediately. The first cycle after reset behaves as an empty pipeline.
- Output paths: all outputs except `stall_cnt` are combinational from the slots and the current inputs. There is no internal combinational loop through `id_ready`.

## Test plan
- **Back-to-back ALU dependency.** Issue `addiu $8`, then an ID instruction reading `$8` on port 1 -> `fwd_sel_1` = 01 and `id_ready` = 1. One cycle later the reader sees 10. Two cycles later it sees 11. Three cycles later it sees 00.
- **Load-use.** `lw $9`, then `beq $9,$0` -> `load_use_stall` = 1 and `id_ready` = 0 for one cycle, with a bubble in EX. Next cycle `fwd_sel_1` = 10 and `id_ready` = 1. `stall_cnt` = 1.
- **Register 0 and priority.**
  - Writes to `$0` followed by reads of `$0` -> select 00 and no stall.
  - EX and MEM both writing `$5` -> `fwd_sel_2` = 01.
- **Memory stall.** `mem_stall` held high for 3 cycles with `id_valid` = 1 -> slots frozen, selects unchanged, `stall_cnt` += 3, no issue.
- **Flush.**
  - `flush` pulse during `mem_stall` -> `flush_pend` = 1. On the release edge the EX slot holds a bubble while the ID instruction is presented, and `flush_pend` returns to 0.
  - `flush` with `mem_stall` = 0 -> the EX slot holds a bubble on the next edge.
- **Saturation and reset.** Force 65 540 stalled cycles -> `stall_cnt` = 16'hFFFF. Asserting `rst` asynchronously mid-cycle -> `stall_cnt` = 0 and all selects = 00 before the next edge.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | id_hazard_ctrl                                                               |
// | ID-stage hazard detection, load-use bubbling and operand bypass selection.  |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module id_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        reg_read_en_1,
  input  logic        reg_read_en_2,
  input  logic [4:0]  reg_addr_1,
  input  logic [4:0]  reg_addr_2,
  input  logic        reg_write_en,
  input  logic [4:0]  reg_write_addr,
  input  logic        id_is_load,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        id_ready,
  output logic [1:0]  fwd_sel_1,
  output logic [1:0]  fwd_sel_2,
  output logic        load_use_stall,
  output logic [15:0] stall_cnt
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;
  localparam logic [1:0]  c_sel_rf  = 2'b00;
  localparam logic [1:0]  c_sel_ex  = 2'b01;
  localparam logic [1:0]  c_sel_mem = 2'b10;
  localparam logic [1:0]  c_sel_wb  = 2'b11;

  // Shadow slots: destination register of each in-flight instruction
  logic       ex_v_q,  ex_v_d;
  logic [4:0] ex_waddr_q, ex_waddr_d;
  logic       ex_ld_q, ex_ld_d;
  logic       mem_v_q, mem_v_d;
  logic [4:0] mem_waddr_q, mem_waddr_d;
  logic       mem_ld_q, mem_ld_d;
  logic       wb_v_q, wb_v_d;
  logic [4:0] wb_waddr_q, wb_waddr_d;
  logic       wb_ld_q, wb_ld_d;
  logic       flush_pend_q, flush_pend_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic hit1_ex, hit1_mem, hit1_wb;
  logic hit2_ex, hit2_mem, hit2_wb;
  logic flush_eff;
  logic issue;

  function automatic logic port_hit(
    input logic       en,
    input logic [4:0] addr,
    input logic       slot_v,
    input logic [4:0] slot_waddr
  );
    return en && (addr != 5'd0) && slot_v && (slot_waddr == addr);
  endfunction

  always_comb begin
    hit1_ex  = port_hit(reg_read_en_1, reg_addr_1, ex_v_q,  ex_waddr_q);
    hit1_mem = port_hit(reg_read_en_1, reg_addr_1, mem_v_q, mem_waddr_q);
    hit1_wb  = port_hit(reg_read_en_1, reg_addr_1, wb_v_q,  wb_waddr_q);
    hit2_ex  = port_hit(reg_read_en_2, reg_addr_2, ex_v_q,  ex_waddr_q);
    hit2_mem = port_hit(reg_read_en_2, reg_addr_2, mem_v_q, mem_waddr_q);
    hit2_wb  = port_hit(reg_read_en_2, reg_addr_2, wb_v_q,  wb_waddr_q);
  end

  // Youngest producer wins so the most recent value is bypassed
  always_comb begin
    fwd_sel_1 = c_sel_rf;
    if (hit1_ex)       fwd_sel_1 = c_sel_ex;
    else if (hit1_mem) fwd_sel_1 = c_sel_mem;
    else if (hit1_wb)  fwd_sel_1 = c_sel_wb;

    fwd_sel_2 = c_sel_rf;
    if (hit2_ex)       fwd_sel_2 = c_sel_ex;
    else if (hit2_mem) fwd_sel_2 = c_sel_mem;
    else if (hit2_wb)  fwd_sel_2 = c_sel_wb;
  end

  // A load result is not available from EX, so any EX hit on a load stalls
  always_comb begin
    load_use_stall = id_valid && ex_ld_q && (hit1_ex || hit2_ex);
    id_ready       = !mem_stall && !load_use_stall;
    flush_eff      = flush || flush_pend_q;
    issue          = id_valid && id_ready && !flush_eff;
  end

  always_comb begin
    ex_v_d       = ex_v_q;
    ex_waddr_d   = ex_waddr_q;
    ex_ld_d      = ex_ld_q;
    mem_v_d      = mem_v_q;
    mem_waddr_d  = mem_waddr_q;
    mem_ld_d     = mem_ld_q;
    wb_v_d       = wb_v_q;
    wb_waddr_d   = wb_waddr_q;
    wb_ld_d      = wb_ld_q;
    flush_pend_d = flush_pend_q;

    if (mem_stall) begin
      // Frozen pipeline: remember a flush until the edge that can honour it
      flush_pend_d = flush_pend_q || flush;
    end else begin
      wb_v_d       = mem_v_q;
      wb_waddr_d   = mem_waddr_q;
      wb_ld_d      = mem_ld_q;
      mem_v_d      = ex_v_q;
      mem_waddr_d  = ex_waddr_q;
      mem_ld_d     = ex_ld_q;
      flush_pend_d = 1'b0;
      if (issue) begin
        ex_v_d     = reg_write_en && (reg_write_addr != 5'd0);
        ex_waddr_d = reg_write_addr;
        ex_ld_d    = id_is_load;
      end else begin
        ex_v_d     = 1'b0;
        ex_waddr_d = 5'd0;
        ex_ld_d    = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_valid && !id_ready && (stall_cnt_q != c_cnt_max)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_q       <= 1'b0;
      ex_waddr_q   <= 5'd0;
      ex_ld_q      <= 1'b0;
      mem_v_q      <= 1'b0;
      mem_waddr_q  <= 5'd0;
      mem_ld_q     <= 1'b0;
      wb_v_q       <= 1'b0;
      wb_waddr_q   <= 5'd0;
      wb_ld_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      ex_v_q       <= ex_v_d;
      ex_waddr_q   <= ex_waddr_d;
      ex_ld_q      <= ex_ld_d;
      mem_v_q      <= mem_v_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_ld_q     <= mem_ld_d;
      wb_v_q       <= wb_v_d;
      wb_waddr_q   <= wb_waddr_d;
      wb_ld_q      <= wb_ld_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_id_hazard_ctrl                                                            |
// | Directed scenarios plus randomized traffic against a slot-array model.      |
// | Rev 1.0 - initial release                                                    |
// +----------------------------------------------------------------------------+
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, reg_read_en_1, reg_read_en_2;
  logic [4:0]  reg_addr_1, reg_addr_2, reg_write_addr;
  logic        reg_write_en, id_is_load, mem_stall, flush;
  logic        id_ready, load_use_stall;
  logic [1:0]  fwd_sel_1, fwd_sel_2;
  logic [15:0] stall_cnt;

  int n_run  = 0;
  int n_fail = 0;

  // Model: index 0 = EX, 1 = MEM, 2 = WB
  bit         mv[3];
  logic [4:0] ma[3];
  bit         ml[3];
  bit         mfp;
  int         mcnt;

  id_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .reg_read_en_1  (reg_read_en_1),
    .reg_read_en_2  (reg_read_en_2),
    .reg_addr_1     (reg_addr_1),
    .reg_addr_2     (reg_addr_2),
    .reg_write_en   (reg_write_en),
    .reg_write_addr (reg_write_addr),
    .id_is_load     (id_is_load),
    .mem_stall      (mem_stall),
    .flush          (flush),
    .id_ready       (id_ready),
    .fwd_sel_1      (fwd_sel_1),
    .fwd_sel_2      (fwd_sel_2),
    .load_use_stall (load_use_stall),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_sel(input logic en, input logic [4:0] a);
    logic [1:0] r;
    r = 2'b00;
    if (en && a != 5'd0)
      for (int s = 2; s >= 0; s--)
        if (mv[s] && ma[s] == a) r = 2'(s + 1);
    return r;
  endfunction

  function automatic logic exp_lus();
    return id_valid && ml[0] &&
           (exp_sel(reg_read_en_1, reg_addr_1) == 2'b01 ||
            exp_sel(reg_read_en_2, reg_addr_2) == 2'b01);
  endfunction

  function automatic logic exp_ready();
    return !mem_stall && !exp_lus();
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin mv[s] = 0; ma[s] = 0; ml[s] = 0; end
    mfp  = 0;
    mcnt = 0;
  endtask

  task automatic model_edge();
    bit rdy, iss;
    rdy = exp_ready();
    iss = id_valid && rdy && !(flush || mfp);
    if (id_valid && !rdy && mcnt < 65535) mcnt++;
    if (!mem_stall) begin
      for (int s = 2; s > 0; s--) begin mv[s] = mv[s-1]; ma[s] = ma[s-1]; ml[s] = ml[s-1]; end
      mv[0] = iss && reg_write_en && reg_write_addr != 0;
      ma[0] = iss ? reg_write_addr : 5'd0;
      ml[0] = iss && id_is_load;
      mfp   = 0;
    end else if (flush) begin
      mfp = 1;
    end
  endtask

  task automatic drive(input logic iv, input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2, input logic we,
                       input logic [4:0] wa, input logic ld, input logic ms,
                       input logic fl);
    id_valid = iv; reg_read_en_1 = r1; reg_addr_1 = a1;
    reg_read_en_2 = r2; reg_addr_2 = a2; reg_write_en = we;
    reg_write_addr = wa; id_is_load = ld; mem_stall = ms; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_run++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", id_ready); end
    n_run++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    drive(1, 1, 5'd3, 1, 5'd4, 0, 0, 0, 1, 0);
    #1;
    n_run++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_ms: got %b want 0", id_ready); end
    n_run++; if ({fwd_sel_1, fwd_sel_2, load_use_stall} !== 5'b0) begin n_fail++;
      $display("FAIL reset_sel: got %b %b %b want 00 00 0", fwd_sel_1, fwd_sel_2, load_use_stall); end
    do_reset();
  endtask

  task automatic test_alu_dep();
    logic [1:0] want[4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b11; want[3] = 2'b00;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5'd8, 0, 0, 0);
    tick();
    drive(1, 1, 5'd8, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_run++; if (fwd_sel_1 !== want[k] || id_ready !== 1'b1) begin n_fail++;
        $display("FAIL alu_dep_%0d: sel=%b ready=%b want sel=%b ready=1", k, fwd_sel_1, id_ready, want[k]); end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5'd9, 1, 0, 0);
    tick();
    drive(1, 1, 5'd9, 1, 5'd0, 0, 0, 0, 0, 0);
    #1;
    n_run++; if (load_use_stall !== 1'b1 || id_ready !== 1'b0) begin n_fail++;
      $display("FAIL load_use_hold: lus=%b ready=%b want 1 0", load_use_stall, id_ready); end
    tick();
    n_run++; if (dut.ex_v_q !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: ex_v=%b want 0", dut.ex_v_q); end
    n_run++; if (load_use_stall !== 1'b0 || id_ready !== 1'b1 || fwd_sel_1 !== 2'b10) begin n_fail++;
      $display("FAIL load_use_release: lus=%b ready=%b sel=%b want 0 1 10", load_use_stall, id_ready, fwd_sel_1); end
    n_run++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_reg0_priority();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5'd0, 1, 0, 0);
    tick();
    drive(1, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0);
    #1;
    n_run++; if (fwd_sel_1 !== 2'b00 || fwd_sel_2 !== 2'b00 || load_use_stall !== 1'b0) begin n_fail++;
      $display("FAIL reg0: sel=%b %b lus=%b want 00 00 0", fwd_sel_1, fwd_sel_2, load_use_stall); end
    drive(1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0);
    tick();
    tick();
    drive(1, 0, 0, 1, 5'd5, 0, 0, 0, 0, 0);
    #1;
    n_run++; if (fwd_sel_2 !== 2'b01) begin n_fail++; $display("FAIL priority_ex: sel2=%b want 01", fwd_sel_2); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5'd8, 0, 0, 0);
    tick();
    drive(1, 1, 5'd8, 0, 0, 1, 5'd10, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_run++; if (fwd_sel_1 !== 2'b01 || id_ready !== 1'b0) begin n_fail++;
        $display("FAIL mem_stall_%0d: sel=%b ready=%b want 01 0", k, fwd_sel_1, id_ready); end
      tick();
    end
    n_run++; if (dut.ex_v_q !== 1'b1 || dut.ex_waddr_q !== 5'd8) begin n_fail++;
      $display("FAIL mem_stall_frozen: ex_v=%b ex_waddr=%0d want 1 8", dut.ex_v_q, dut.ex_waddr_q); end
    n_run++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL mem_stall_cnt: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5'd7, 0, 1, 1);
    tick();
    n_run++; if (dut.flush_pend_q !== 1'b1) begin n_fail++; $display("FAIL flush_pend_set: got %b want 1", dut.flush_pend_q); end
    drive(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
    tick();
    n_run++; if (dut.ex_v_q !== 1'b0 || dut.flush_pend_q !== 1'b0) begin n_fail++;
      $display("FAIL flush_pend_release: ex_v=%b pend=%b want 0 0", dut.ex_v_q, dut.flush_pend_q); end
    drive(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 1);
    tick();
    n_run++; if (dut.ex_v_q !== 1'b0) begin n_fail++; $display("FAIL flush_direct: ex_v=%b want 0", dut.ex_v_q); end
    drive(1, 0, 0, 0, 0, 1, 5'd7, 0, 0, 0);
    tick();
    n_run++; if (dut.ex_v_q !== 1'b1 || dut.ex_waddr_q !== 5'd7) begin n_fail++;
      $display("FAIL flush_after: ex_v=%b ex_waddr=%0d want 1 7", dut.ex_v_q, dut.ex_waddr_q); end
  endtask

  task automatic test_random();
    logic [1:0] e1, e2;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 5) != 0, $urandom % 2, 5'($urandom % 4), $urandom % 2, 5'($urandom % 4),
            ($urandom % 4) != 0, 5'($urandom % 4), ($urandom % 3) == 0,
            ($urandom % 4) == 0, ($urandom % 10) == 0);
      #1;
      e1 = exp_sel(reg_read_en_1, reg_addr_1);
      e2 = exp_sel(reg_read_en_2, reg_addr_2);
      n_run++; if (fwd_sel_1 !== e1 || fwd_sel_2 !== e2) begin n_fail++;
        $display("FAIL rand_sel[%0d]: got %b %b want %b %b", i, fwd_sel_1, fwd_sel_2, e1, e2); end
      n_run++; if (load_use_stall !== exp_lus() || id_ready !== exp_ready()) begin n_fail++;
        $display("FAIL rand_hs[%0d]: lus=%b ready=%b want %b %b", i, load_use_stall, id_ready, exp_lus(), exp_ready()); end
      n_run++; if (stall_cnt !== 16'(mcnt)) begin n_fail++;
        $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cnt, mcnt); end
      tick();
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 65540; i++) tick();
    n_run++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL saturate: got %h want ffff", stall_cnt); end
    drive(1, 0, 0, 0, 0, 1, 5'd8, 0, 0, 0);
    tick();
    drive(1, 1, 5'd8, 1, 5'd8, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_run++; if (stall_cnt !== 16'd0 || fwd_sel_1 !== 2'b00 || fwd_sel_2 !== 2'b00) begin n_fail++;
      $display("FAIL async_reset: cnt=%0d sel=%b %b want 0 00 00", stall_cnt, fwd_sel_1, fwd_sel_2); end
    rst = 1'b0;
    model_reset();
    tick();
    n_run++; if (dut.ex_v_q !== 1'b0 || fwd_sel_1 !== 2'b00) begin n_fail++;
      $display("FAIL post_reset: ex_v=%b sel=%b want 0 00", dut.ex_v_q, fwd_sel_1); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu_dep();
    test_load_use();
    test_reg0_priority();
    test_mem_stall();
    test_flush();
    test_random();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
